regfile_arbiter: RTL and testbench

Shares one single-port 8-entry × 8-bit register file between two requesters: port A (I2C slave application interface) and port B (local logic such as the dice roller publishing its result). It has a round-robin arbiter with a req/gnt handshake and a one-cycle registered read path. It also supports an optional A-side burst lock with a starvation guard. It replaces ad-hoc shared memory writes so that host and local updates can never collide.

---
 rtl/regfile_arbiter_pkg.sv | 12 +
 rtl/regfile_arbiter_mem.sv | 45 ++++
 rtl/regfile_arbiter.sv | 171 +++++++++++++++++
 tb/tb_regfile_arbiter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/regfile_arbiter_pkg.sv
// Shared constants for the two-port register-file arbiter.
// Default geometry, starvation limit and owner encoding.
package regfile_arbiter_pkg;

    localparam int ADDR_W_DEF     = 3;
    localparam int DATA_W_DEF     = 8;
    localparam int STARVE_MAX_DEF = 15;

    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

endpackage

// File: rtl/regfile_arbiter_mem.sv
// Single-port register storage for the arbiter.
// Synchronous write, registered read, all entries reset to zero.
module regfile_arbiter_mem
    import regfile_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage array: clear on reset, write on a granted write access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register: sample the addressed entry on a granted read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter sharing one register file between ports A and B.
// Optional A burst lock with starvation guard: REGFILE_ARBITER_LOCK_EN.
module regfile_arbiter
    import regfile_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_lock,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic              r_last_owner;
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [DATA_W-1:0] r_a_hold;
    logic [DATA_W-1:0] r_b_hold;

    logic              w_a_gnt;
    logic              w_b_gnt;
    logic              w_lock_act;
    logic              w_mem_we;
    logic              w_mem_re;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_mem_rdata;

`ifdef REGFILE_ARBITER_LOCK_EN
    logic             r_lock_owner;
    logic [CNT_W-1:0] r_starve_cnt;
    logic             w_starve_max;
    logic             w_locking;

    assign w_starve_max = (r_starve_cnt == CNT_W'(STARVE_MAX));
    assign w_locking    = r_lock_owner | (w_a_gnt & a_lock);
    // A starved B long enough: the lock stops counting as active
    assign w_lock_act   = r_lock_owner & a_lock & ~w_starve_max;

    // Lock ownership: taken on a locked A grant, dropped on release or starvation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_owner <= 1'b0;
        end else if (w_starve_max) begin
            r_lock_owner <= 1'b0;
        end else if (w_a_gnt && a_lock) begin
            r_lock_owner <= 1'b1;
        end else if (!a_lock) begin
            r_lock_owner <= 1'b0;
        end
    end

    // Starvation counter: cycles B waits behind a lock, cleared on B grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_b_gnt || !w_locking) begin
            r_starve_cnt <= '0;
        end else if (b_req && !w_starve_max) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end
`else
    logic w_unused;

    assign w_lock_act = 1'b0;
    assign w_unused   = ^{a_lock, CNT_W'(STARVE_MAX)};
`endif

    // Grant decision: lock first, then round-robin on a tie
    always_comb begin
        w_a_gnt = 1'b0;
        w_b_gnt = 1'b0;
        if (!rst_n) begin
            w_a_gnt = 1'b0;
        end else if (w_lock_act && a_req) begin
            w_a_gnt = 1'b1;
        end else if (a_req && b_req) begin
            if (r_last_owner == OWN_A) begin
                w_b_gnt = 1'b1;
            end else begin
                w_a_gnt = 1'b1;
            end
        end else if (a_req) begin
            w_a_gnt = 1'b1;
        end else if (b_req) begin
            w_b_gnt = 1'b1;
        end
    end

    assign a_gnt = w_a_gnt;
    assign b_gnt = w_b_gnt;

    assign w_mem_addr  = w_b_gnt ? b_addr : a_addr;
    assign w_mem_wdata = w_b_gnt ? b_wdata : a_wdata;
    assign w_mem_we    = (w_a_gnt & a_we) | (w_b_gnt & b_we);
    assign w_mem_re    = (w_a_gnt & ~a_we) | (w_b_gnt & ~b_we);

    regfile_arbiter_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    // Remember who was served last so the other side wins the next tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_owner <= OWN_B;
        end else if (w_a_gnt) begin
            r_last_owner <= OWN_A;
        end else if (w_b_gnt) begin
            r_last_owner <= OWN_B;
        end
    end

    // One-cycle read-valid pulses per port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
        end else begin
            r_a_rvalid <= w_a_gnt & ~a_we;
            r_b_rvalid <= w_b_gnt & ~b_we;
        end
    end

    // Per-port copy of the last read so rdata survives the other port's reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_hold <= '0;
            r_b_hold <= '0;
        end else begin
            if (r_a_rvalid) begin
                r_a_hold <= w_mem_rdata;
            end
            if (r_b_rvalid) begin
                r_b_hold <= w_mem_rdata;
            end
        end
    end

    assign a_rvalid = r_a_rvalid;
    assign b_rvalid = r_b_rvalid;
    assign a_rdata  = r_a_rvalid ? w_mem_rdata : r_a_hold;
    assign b_rdata  = r_b_rvalid ? w_mem_rdata : r_b_hold;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: handshake, round-robin, lock, reset.
// Lock expectations follow REGFILE_ARBITER_LOCK_EN as built.
module tb_regfile_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_we, a_lock;
    logic [2:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_gnt, a_rvalid;
    logic [7:0] a_rdata;
    logic       b_req, b_we;
    logic [2:0] b_addr;
    logic [7:0] b_wdata;
    logic       b_gnt, b_rvalid;
    logic [7:0] b_rdata;

    int n_tot  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_req    (a_req),
        .a_we     (a_we),
        .a_addr   (a_addr),
        .a_wdata  (a_wdata),
        .a_lock   (a_lock),
        .a_gnt    (a_gnt),
        .a_rvalid (a_rvalid),
        .a_rdata  (a_rdata),
        .b_req    (b_req),
        .b_we     (b_we),
        .b_addr   (b_addr),
        .b_wdata  (b_wdata),
        .b_gnt    (b_gnt),
        .b_rvalid (b_rvalid),
        .b_rdata  (b_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0;
        b_req = 1'b0; b_we = 1'b0;
    endtask

    task automatic pulse_rst();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic acc(input bit pb, input bit we,
                       input logic [2:0] addr, input logic [7:0] d);
        if (pb) begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d;
        end else begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d;
        end
        #1;
        chk(pb ? "b_gnt" : "a_gnt", pb ? b_gnt : a_gnt, 1);
        cyc();
        idle();
    endtask

    initial begin
        int first_b;
        int na;

        rst_n = 1'b0;
        idle();
        a_addr = '0; a_wdata = '0; b_addr = '0; b_wdata = '0;
        a_req = 1'b1;
        #2;
        chk("rst_a_gnt", a_gnt, 0);
        chk("rst_a_rvalid", a_rvalid, 0);
        chk("rst_a_rdata", a_rdata, 0);
        a_req = 1'b0;
        #10;
        rst_n = 1'b1;
        cyc();

        acc(1, 1, 3'd3, 8'h5A);
        acc(0, 0, 3'd3, 8'h00);
        chk("rd_a_rvalid", a_rvalid, 1);
        chk("rd_a_rdata", a_rdata, 8'h5A);
        cyc();
        chk("rd_a_pulse", a_rvalid, 0);
        chk("rd_a_hold", a_rdata, 8'h5A);

        pulse_rst();
        cyc();
        a_req = 1'b1; a_we = 1'b0; a_addr = 3'd0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 3'd1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk($sformatf("rr_a%0d", i), a_gnt, (i % 2) == 0);
            chk($sformatf("rr_b%0d", i), b_gnt, (i % 2) == 1);
            cyc();
        end
        idle();

        pulse_rst();
        cyc();
        first_b = 0;
        na = 0;
        a_req = 1'b1; a_lock = 1'b1; a_we = 1'b0;
        b_req = 1'b1; b_we = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (b_gnt) first_b = c;
            else if (a_gnt) na++;
            cyc();
            if (first_b != 0) break;
        end
`ifdef REGFILE_ARBITER_LOCK_EN
        chk("lock_a_cnt", na, 15);
        chk("lock_first_b", first_b, 16);
`else
        chk("nolock_a_cnt", na, 1);
        chk("nolock_first_b", first_b, 2);
`endif
        #1;
        chk("lock_after_a", a_gnt, 1);
        chk("lock_after_b", b_gnt, 0);
        cyc();
        a_req = 1'b0;
        #1;
        chk("lock_idle_a_b", b_gnt, 1);
        cyc();
        idle();

        acc(0, 1, 3'd2, 8'h11);
        acc(0, 0, 3'd2, 8'h00);
        chk("mid_rvalid", a_rvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rvalid_clr", a_rvalid, 0);
        chk("mid_rdata_clr", a_rdata, 0);
        rst_n = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            acc(1, 0, 3'(i), 8'h00);
            chk($sformatf("clr_e%0d", i), b_rdata, 0);
        end

        acc(0, 1, 3'd7, 8'hFF);
        acc(1, 0, 3'd7, 8'h00);
        chk("raw_b_rvalid", b_rvalid, 1);
        chk("raw_b_rdata", b_rdata, 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
